// File: rtl/csr_regfile_apb.sv
// csr_regfile_apb: NUM_REGS x DATA_WIDTH control/status register file behind
// an APB slave port. Each bit is software-writable, write-1-to-clear
// (hardware-set) or read-only, and each register has a hardware update strobe.
// Register contents drive the peripheral core directly. A level interrupt is
// raised from the status and enable registers.
//
// Handshake: a transfer begins with the APB setup phase (psel=1, penable=0)
// and is held by the master (psel=1, penable=1, stable paddr/pwrite/pwdata)
// until the slave returns pready=1. pready is high for exactly one cycle, and
// the commit happens at the clock edge that ends that cycle. prdata and
// pslverr are meaningful only while pready=1 and are 0 otherwise. If psel
// drops before that edge, the transfer is abandoned and nothing is committed.
module csr_regfile_apb #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned NUM_REGS    = 4,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] SW_WR_MASK = '1,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] W1C_MASK   = '0,
   parameter int unsigned STATUS_IDX  = 2,
   parameter int unsigned IRQEN_IDX   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_next,
   input  logic [NUM_REGS-1:0]            hw_we,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_value,
   output logic                           wrcol,
   output logic                           irq,
   output logic [1:0]                     dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

   state_e                        state_q, state_d;
   logic [2:0]                    cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic                          wr_q, wr_d;
   logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
   logic                          pready_q, pready_d;
   logic                          pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]         prdata_q, prdata_d;
   logic                          wrcol_q, wrcol_d;
   logic                          irq_q, irq_d;
   logic                          commit;
   logic                          addr_ok_q, addr_ok_d;

   // Address decode for the captured address and for the one about to be captured.
   assign addr_ok_q = (32'(addr_q) < NUM_REGS);
   assign addr_ok_d = (32'(addr_d) < NUM_REGS);

   // Transfer FSM: captures the request in SETUP, counts wait states in ACCESS.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) state_d = SETUP;
         end
         SETUP: begin
            if (!psel) begin
               state_d = IDLE;
            end else begin
               state_d = ACCESS;
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               cnt_d   = WAIT_LOAD;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q == 3'd0) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-bit register update: W1C bits, writable bits and read-only bits.
   always_comb begin
      logic [DATA_WIDTH-1:0] cur, hwv, w1c, wm, ro, sw_v, nxt;
      logic                  sw;
      cur     = '0;
      hwv     = '0;
      w1c     = '0;
      wm      = '0;
      ro      = '0;
      sw_v    = '0;
      nxt     = '0;
      sw      = 1'b0;
      regs_d  = regs_q;
      wrcol_d = 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         sw   = commit && wr_q && addr_ok_q && (addr_q == ADDR_WIDTH'(i));
         cur  = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
         hwv  = hw_next[i*DATA_WIDTH +: DATA_WIDTH];
         w1c  = W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH];
         wm   = SW_WR_MASK[i*DATA_WIDTH +: DATA_WIDTH] & ~w1c;
         ro   = ~w1c & ~wm;
         sw_v = {DATA_WIDTH{sw}};
         nxt  = (w1c & ((cur & ~(sw_v & wdata_q)) | ({DATA_WIDTH{hw_we[i]}} & hwv)))
              | (wm  & (hw_we[i] ? hwv : (sw ? wdata_q : cur)))
              | (ro  & (hw_we[i] ? hwv : cur));
         regs_d[i*DATA_WIDTH +: DATA_WIDTH] = nxt;
         if (sw && hw_we[i]) wrcol_d = 1'b1;
      end
   end

   // Response for the cycle being entered; read data is the register value held
   // during the commit cycle, i.e. before that cycle's own update.
   always_comb begin
      pready_d  = (state_d == ACCESS) && (cnt_d == 3'd0);
      pslverr_d = pready_d && !addr_ok_d;
      prdata_d  = '0;
      if (pready_d && !wr_d && addr_ok_d) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (addr_d == ADDR_WIDTH'(i)) prdata_d = regs_d[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      irq_d = |(regs_q[STATUS_IDX*DATA_WIDTH +: DATA_WIDTH] &
                regs_q[IRQEN_IDX*DATA_WIDTH +: DATA_WIDTH]);
   end

   // State, captured request, registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         regs_q    <= RESET_VAL;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         wrcol_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         regs_q    <= regs_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         wrcol_q   <= wrcol_d;
         irq_q     <= irq_d;
      end
   end

   assign pready      = pready_q;
   assign pslverr     = pslverr_q;
   assign prdata      = prdata_q;
   assign reg_value   = regs_q;
   assign wrcol       = wrcol_q;
   assign irq         = irq_q;
   assign dbg_state_o = state_q;

endmodule
